// File: rtl/bit_stream_serializer_pkg.sv
// Shared constants for the bit-stream serializer: FSM state encoding,
// default word width, idle line level and the parity helper.
package seq_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  // Even parity over a zero-extended word (zero padding does not change it).
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Load handshake and serial output bundle of the bit-stream serializer.
interface bit_stream_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output load_data, load_valid,
    input  load_ready, ser_out, ser_valid, frame_done, busy
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, ser_out, ser_valid, frame_done, busy
  );

endinterface

// File: rtl/bit_stream_serializer_shift_reg.sv
// ser_shift_reg: WIDTH-bit loadable left-shift register exposing its MSB.
module ser_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/bit_stream_serializer.sv
// MSB-first parallel-to-serial stage with valid/ready load and frame_done.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module bit_stream_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_stream_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int CW = $clog2(WIDTH) + 1;
`else
  localparam int CW = $clog2(WIDTH);
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_valid_q, ser_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          load_ready_s;
  logic          accept_s;
  logic          shift_en_s;
  logic          shreg_msb_s;

  always_comb begin
    load_ready_s = 1'b0;
    if (rst) begin
      load_ready_s = 1'b0;
    end else if (state_q == S_IDLE) begin
      load_ready_s = 1'b1;
`ifdef SER_PARITY_EN
    end else if (state_q == S_PARITY) begin
      load_ready_s = 1'b1;
`else
    end else if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
      load_ready_s = 1'b1;
`endif
    end else begin
      load_ready_s = 1'b0;
    end
  end

  assign accept_s   = bus.load_valid && load_ready_s;
  assign shift_en_s = (state_q == S_SHIFT) && (cnt_q != CNT_LAST);

  // Shift register holds the word pre-shifted by one, so its MSB is always the next bit.
  ser_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .shift_en (shift_en_s),
    .load_val ({bus.load_data[WIDTH-2:0], 1'b0}),
    .msb      (shreg_msb_s)
  );

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    if (accept_s) begin
      parity_d = even_parity(32'(bus.load_data));
    end else begin
      parity_d = parity_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = accept_s ? S_SHIFT : S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
      S_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q + CW'(1'b1);
        end else begin
          cnt_d   = {CW{1'b0}};
`ifdef SER_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = accept_s ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        state_d = accept_s ? S_SHIFT : S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Outputs are registered, so they are computed from the next state.
  always_comb begin
    ser_out_d    = IDLE_LEVEL;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = 1'b0;
    if (state_d == S_SHIFT) begin
      ser_out_d    = accept_s ? bus.load_data[WIDTH-1] : shreg_msb_s;
      ser_valid_d  = 1'b1;
      busy_d       = 1'b1;
`ifdef SER_PARITY_EN
      frame_done_d = 1'b0;
    end else if (state_d == S_PARITY) begin
      ser_out_d    = parity_q;
      ser_valid_d  = 1'b1;
      busy_d       = 1'b1;
      frame_done_d = 1'b1;
`else
      frame_done_d = (cnt_d == CNT_LAST);
`endif
    end else begin
      ser_out_d    = IDLE_LEVEL;
      ser_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      ser_out_q    <= IDLE_LEVEL;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule
